// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, the
// memory-mapped TX register address and the default baud divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [15:0] UART_TX_ADDR         = 16'hF000;
    localparam int          DEFAULT_CLKS_PER_BIT = 868;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between CPU stores and the serial shifter. Storage has no
// reset so it maps onto distributed RAM with an asynchronous read port.
// Full/empty come from the occupancy counter; pointers simply wrap.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A push into a full FIFO still lands if a pop frees a slot this cycle.
    assign wr_ok = push & (~full | pop);
    assign rd_ok = pop & ~empty;

    // Storage write port, no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end

    // Pointers, occupancy and the dropped-push pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            count    <= count + CW'(wr_ok) - CW'(rd_ok);
            overflow <= push & ~wr_ok;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered 8-bit frames, LSB first, idle-high line.
// Optional even parity bit selected by defining UART_TX_PARITY_EN
// (8E1/8E2); without it frames are 8N1/8N2.
// tx and busy are registered from the current state, so the line lags the
// FSM by one cycle uniformly and every bit still lasts CLKS_PER_BIT cycles.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_en,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

    tx_state_t   state;
    logic [BW-1:0] baud;
    logic [2:0]  bit_idx;
    logic [7:0]  data_q;
    logic        stop_cnt;
    logic        bit_end;
    logic        stop_last;
    logic        pop;
    logic [7:0]  fifo_dout;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (wr_en),
        .din      (wr_data),
        .pop      (pop),
        .dout     (fifo_dout),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign bit_end   = (baud == '0);
    assign stop_last = (STOP_BITS == 2) ? stop_cnt : 1'b1;

    // Pop when idle, or on the final stop cycle so frames run back to back.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == IDLE)
                pop = 1'b1;
            else if (state == STOP && bit_end && stop_last)
                pop = 1'b1;
        end
    end

    // Frame sequencer with baud counter and registered line/busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            data_q   <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            busy <= (state != IDLE) | ~fifo_empty;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        data_q <= fifo_dout;
                        baud   <= BAUD_LOAD;
                        state  <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (bit_end) begin
                        baud    <= BAUD_LOAD;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud - BW'(1);
                    end
                end
                DATA: begin
                    tx <= data_q[bit_idx];
                    if (bit_end) begin
                        baud <= BAUD_LOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            stop_cnt <= 1'b0;
                            state    <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud - BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx <= even_parity(data_q);
                    if (bit_end) begin
                        baud     <= BAUD_LOAD;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end else begin
                        baud <= baud - BW'(1);
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        if (stop_last) begin
                            if (pop) begin
                                data_q <= fifo_dout;
                                baud   <= BAUD_LOAD;
                                state  <= START;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                            baud     <= BAUD_LOAD;
                        end
                    end else begin
                        baud <= baud - BW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4, STOP_BITS=1.
// Reference model: a byte queue plus a "cycles left in current frame"
// timer; expected line level is the frame bit at the elapsed offset.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int SB    = 1;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 1 + 8 + 1 + SB;
`else
    localparam int NBITS = 1 + 8 + SB;
`endif
    localparam int B = NBITS * CPB;

    logic       clk;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int ovf_seen = 0;

    logic [7:0] q[$];
    int         rem = 0;
    logic [7:0] cur = 8'h00;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .STOP_BITS    (SB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line level at offset p cycles into a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int p);
        int i;
        i = p / CPB;
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic cycle(input logic en, input logic [7:0] d);
        logic e_tx, e_busy, e_ovf, do_pop, acc;
        wr_en   = en;
        wr_data = d;
        @(posedge clk);
        e_tx   = (rem > 0) ? frame_bit(cur, B - rem) : 1'b1;
        e_busy = (rem > 0) || (q.size() > 0);
        do_pop = (rem <= 1) && (q.size() > 0);
        acc    = en && ((q.size() < DEPTH) || do_pop);
        e_ovf  = en && !acc;
        if (do_pop) begin
            cur = q.pop_front();
            rem = B;
        end else if (rem > 0) begin
            rem--;
        end
        if (acc) q.push_back(d);
        #1;
        check("tx", tx, e_tx);
        check("busy", busy, e_busy);
        check("fifo_count", fifo_count, q.size());
        check("fifo_empty", fifo_empty, q.size() == 0);
        check("fifo_full", fifo_full, q.size() == DEPTH);
        check("overflow", overflow, e_ovf);
        if (overflow) ovf_seen++;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;

        // Single byte, then idle until well past the stop bit.
        cycle(1'b1, 8'h55);
        idle(B + 6);

        // Back-to-back frames: no gap between stop and next start.
        cycle(1'b1, 8'h00);
        cycle(1'b1, 8'hFF);
        idle(2 * B + 6);

        // Overflow: six pushes while idle, exactly one dropped.
        ovf_seen = 0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'h10 + 8'(i));
        check("ovf_hold_count", fifo_count, DEPTH);
        idle(5 * B + 6);
        check("ovf_pulses", ovf_seen, 1);

        // Parity-sensitive bytes (plain stop bits in the default build).
        cycle(1'b1, 8'h07);
        cycle(1'b1, 8'h03);
        idle(2 * B + 6);

        // Reset during data bit 3 of 0xA5 with two bytes queued.
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h11);
        cycle(1'b1, 8'h22);
        guard = 0;
        while (!(rem > 0 && cur == 8'hA5 && (B - rem) == 4 * CPB + 2) && guard < 200) begin
            cycle(1'b0, 8'h00);
            guard++;
        end
        check("midrst_reached", guard < 200, 1);
        check("midrst_tx_low_before", tx, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_count", fifo_count, 0);
        check("midrst_busy", busy, 0);
        q.delete();
        rem = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3 * B);

        // Randomized traffic: sparse, moderate and bursty phases.
        for (int blk = 0; blk < 6; blk++) begin
            int thr;
            thr = (blk % 3 == 0) ? 4 : ((blk % 3 == 1) ? 25 : 85);
            repeat (300) cycle($urandom_range(0, 99) < thr, 8'($urandom));
        end
        idle((DEPTH + 2) * B + 8);
        check("drain_empty", fifo_empty, 1);
        check("drain_tx", tx, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
